alu_issue_sequencer: RTL and testbench
======================================

Name: alu_issue_sequencer

Overview:
- Drives the ALU's operand/function interface, i.e. the stimulus end of it; the ALU is the consumer.
- Accepts one RV32I integer instruction at a time (OP 0110011 or OP-IMM 0010011) over a valid/ready handshake.
- Decodes the instruction and reads operands from an internal 32x32 register file.
- Drives the ALU, waits the ALU latency, then writes the result back to rd and pulses done.

Parameters:
- ALU_LATENCY, 1, cycles from alu_enable rising to a valid alu_data_out; legal range 1..8.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept.
- instruction  in  32  RV32I instruction word.
- done  out  1  one-cycle pulse when an instruction retires.
- illegal  out  1  qualifies done; instruction was rejected.
- busy  out  1  high in any state other than IDLE.
- alu_enable  out  1  ALU enable.
- alu_funct3  out  3  to ALU funct3.
- alu_funct7  out  7  to ALU funct7.
- alu_data_1  out  32  ALU operand 1 (rs1 value).
- alu_data_2  out  32  ALU operand 2 (rs2 value or immediate).
- alu_data_out  in  32  ALU result.
- dbg_addr  in  5  register-file debug read address.
- dbg_data  out  32  combinational read of regfile[dbg_addr].

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset_n` is asynchronous and active-low.
- Reset values: every output is 0, except instr_ready = 1 once the block is in IDLE. All 32 registers clear to 0. The FSM enters IDLE.
- FSM states: IDLE, ISSUE, EXEC, WB, DONE.
- IDLE:
  - instr_ready = 1.
  - On instr_valid & instr_ready, latch `instruction` and go to ISSUE.
  - instr_ready = 0 in every other state, so the block accepts at most one instruction in flight.
- ISSUE (one cycle): decode the latched word.
  - If illegal, go to DONE with the illegal flag set; alu_enable stays 0 and there is no write.
  - Otherwise register the ALU outputs, load the latency counter with ALU_LATENCY, and go to EXEC.
- Operand rules:
  - alu_data_1 = regfile[rs1].
  - OP: alu_data_2 = regfile[rs2]; alu_funct7 = instr[31:25].
  - OP-IMM: alu_data_2 = sign-extended instr[31:20].
    - Shifts (funct3 001/101): alu_funct7 = instr[31:25].
    - All other funct3: alu_funct7 = 0000000, so ADDI never appears to the ALU as SUB.
  - x0 always reads as 0.
- Illegal encodings:
  - opcode is neither OP nor OP-IMM;
  - OP with funct7 not in {0000000, 0100000};
  - OP with funct7 = 0100000 and funct3 not in {000, 101};
  - OP-IMM SLLI with instr[31:25] ≠ 0000000;
  - OP-IMM SRLI/SRAI with instr[31:25] not in {0000000, 0100000}.
- EXEC (ALU_LATENCY cycles): alu_enable = 1. The counter decrements each cycle; at 1 the FSM goes to WB.
- WB (one cycle):
  - alu_enable = 0; the operand and funct outputs stay held at their ISSUE values.
  - Sample alu_data_out and write it to rd at the closing edge.
  - A write to rd = 0 is suppressed.
- DONE (one cycle): done = 1; illegal = the latched flag. Next state is IDLE.
- Latency:
  - Accept edge ends cycle 0.
  - Legal instruction: done in cycle 3 + ALU_LATENCY.
  - Illegal instruction: done in cycle 2.
  - Back-to-back: the next instruction can be accepted in the cycle after DONE.
- Outputs returning to IDLE: alu_* outputs keep their last values; alu_enable stays 0.
- dbg_data: combinational. It reflects a WB write from the cycle after WB, i.e. by the DONE cycle.
- instr_valid while not ready: ignored. The source must hold the instruction until the handshake completes.
- Reset mid-operation: the in-flight instruction is dropped, with no write and no done. The register file clears and all outputs return to reset values immediately.

Decomposition:
- Shared package `rv_isa_pkg`:
  - opcode constants OPC_OP, OPC_OP_IMM;
  - funct7 constants F7_BASE, F7_ALT;
  - funct3 encodings;
  - FSM state typedef;
  - field-extract helper for rs1/rs2/rd/imm_i.
- One sub-module `rv_regfile_32x32`:
  - two combinational read ports (rs1, rs2) plus the debug read port;
  - one write port;
  - async active-low clear;
  - x0 hardwired to 0.

Test Plan:
- ADDI x1,x0,5 (0x00500093), ALU_LATENCY=1 → alu_funct3=000, alu_funct7=0000000, alu_data_2=0x00000005, alu_enable high exactly 1 cycle; done in cycle 4; dbg_addr=1 reads 0x00000005.
- Then ADDI x2,x0,-3 (0xFFD00113) and ADD x3,x1,x2 (0x002081B3) → alu_data_2 = 0xFFFFFFFD for the ADDI; alu_data_1=5 and alu_data_2=0xFFFFFFFD for the ADD; x3 = 0x00000002.
- SUB x4,x1,x2 (0x40208233) → alu_funct7=0100000; x4 = 0x00000008.
- ADDI x0,x0,7 (0x00700013) → done pulses; dbg x0 = 0.
- JAL (0x0000006F) → done and illegal together in cycle 2; alu_enable never asserted; no register changes.
- ALU_LATENCY=4: assert reset_n low during the 2nd EXEC cycle → all outputs 0 at once, no done, x1 reads 0, instr_ready=1 after release.

Source files
------------

// File: rtl/rv_isa_pkg.sv
// Shared RV32I decode constants, sequencer state type and instruction field helpers.
package rv_isa_pkg;

  // Major opcodes this sequencer accepts.
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  // funct7 values: base encoding and the alternate (SUB / SRA / SRAI).
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // funct3 encodings that affect legality and funct7 forwarding.
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SR      = 3'b101;

  // Sequencer FSM states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_EXEC,
    ST_WB,
    ST_DONE
  } seq_state_e;

  // Register indices and the sign-extended I-type immediate of one instruction.
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm_i;
  } rv_fields_t;

  function automatic rv_fields_t extract_fields(input logic [31:0] instr);
    rv_fields_t f;
    f.rs1   = instr[19:15];
    f.rs2   = instr[24:20];
    f.rd    = instr[11:7];
    f.imm_i = {{20{instr[31]}}, instr[31:20]};
    return f;
  endfunction

endpackage

// File: rtl/rv_regfile_32x32.sv
// 32 x 32-bit integer register file: two operand read ports, one debug read
// port, one write port. x0 always reads as zero and is never written.
module rv_regfile_32x32
  import rv_isa_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [4:0]  rs1_addr_i,
  output logic [31:0] rs1_data_o,
  input  logic [4:0]  rs2_addr_i,
  output logic [31:0] rs2_data_o,
  input  logic [4:0]  dbg_addr_i,
  output logic [31:0] dbg_data_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);

  logic [31:0] regs_q [32];

  // Storage: whole file clears on reset; writes to x0 are dropped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 32; k++) begin
        regs_q[k] <= '0;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Combinational reads with x0 forced to zero.
  assign rs1_data_o = (rs1_addr_i == 5'd0) ? 32'd0 : regs_q[rs1_addr_i];
  assign rs2_data_o = (rs2_addr_i == 5'd0) ? 32'd0 : regs_q[rs2_addr_i];
  assign dbg_data_o = (dbg_addr_i == 5'd0) ? 32'd0 : regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_sequencer.sv
// Accepts one OP / OP-IMM instruction at a time, reads its operands, drives an
// external ALU with a fixed latency, writes the result back and pulses done.
module alu_issue_sequencer
  import rv_isa_pkg::*;
#(
  // Cycles from alu_enable rising to a valid alu_data_out (1..8).
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instruction,
  output logic        done,
  output logic        illegal,
  output logic        busy,
  output logic        alu_enable,
  output logic [2:0]  alu_funct3,
  output logic [6:0]  alu_funct7,
  output logic [31:0] alu_data_1,
  output logic [31:0] alu_data_2,
  input  logic [31:0] alu_data_out,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  localparam logic [3:0] LAT_INIT = 4'(ALU_LATENCY);

  seq_state_e  state_q;
  logic [31:0] instr_q;
  logic [3:0]  cnt_q;
  logic        done_q;
  logic        illegal_q;
  logic        alu_enable_q;
  logic [2:0]  alu_funct3_q;
  logic [6:0]  alu_funct7_q;
  logic [31:0] alu_data_1_q;
  logic [31:0] alu_data_2_q;

  rv_fields_t  fields;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        dec_illegal;
  logic [6:0]  dec_funct7;
  logic [31:0] dec_operand_2;

  assign fields = extract_fields(instr_q);
  assign opcode = instr_q[6:0];
  assign funct3 = instr_q[14:12];
  assign funct7 = instr_q[31:25];

  rv_regfile_32x32 u_regfile (
    .clock      (clock),
    .reset_n    (reset_n),
    .rs1_addr_i (fields.rs1),
    .rs1_data_o (rs1_data),
    .rs2_addr_i (fields.rs2),
    .rs2_data_o (rs2_data),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data),
    .we_i       (state_q == ST_WB),
    .waddr_i    (fields.rd),
    .wdata_i    (alu_data_out)
  );

  // Decode the latched word: legality, second operand and the funct7 the ALU sees.
  // Non-shift OP-IMM forwards funct7 = 0 so immediate bit 30 never turns ADDI into SUB.
  always_comb begin
    dec_illegal   = 1'b0;
    dec_funct7    = F7_BASE;
    dec_operand_2 = rs2_data;
    case (opcode)
      OPC_OP: begin
        dec_funct7 = funct7;
        if (funct7 == F7_ALT) begin
          dec_illegal = !((funct3 == F3_ADD_SUB) || (funct3 == F3_SR));
        end else if (funct7 != F7_BASE) begin
          dec_illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec_operand_2 = fields.imm_i;
        if (funct3 == F3_SLL) begin
          dec_funct7  = funct7;
          dec_illegal = (funct7 != F7_BASE);
        end else if (funct3 == F3_SR) begin
          dec_funct7  = funct7;
          dec_illegal = !((funct7 == F7_BASE) || (funct7 == F7_ALT));
        end
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Sequencer FSM with all handshake and ALU outputs registered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      instr_q      <= '0;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
      alu_enable_q <= 1'b0;
      alu_funct3_q <= '0;
      alu_funct7_q <= '0;
      alu_data_1_q <= '0;
      alu_data_2_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (instr_valid) begin
            instr_q <= instruction;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (dec_illegal) begin
            done_q    <= 1'b1;
            illegal_q <= 1'b1;
            state_q   <= ST_DONE;
          end else begin
            alu_enable_q <= 1'b1;
            alu_funct3_q <= funct3;
            alu_funct7_q <= dec_funct7;
            alu_data_1_q <= rs1_data;
            alu_data_2_q <= dec_operand_2;
            cnt_q        <= LAT_INIT;
            state_q      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt_q <= 4'd1) begin
            alu_enable_q <= 1'b0;
            state_q      <= ST_WB;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_WB: begin
          done_q    <= 1'b1;
          illegal_q <= 1'b0;
          state_q   <= ST_DONE;
        end
        ST_DONE: begin
          done_q    <= 1'b0;
          illegal_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign alu_enable  = alu_enable_q;
  assign alu_funct3  = alu_funct3_q;
  assign alu_funct7  = alu_funct7_q;
  assign alu_data_1  = alu_data_1_q;
  assign alu_data_2  = alu_data_2_q;

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Bench for alu_issue_sequencer: two instances (latency 1 and 4), a latency-
// accurate ALU stand-in, a directed vector table, a mid-flight reset sequence
// and randomized instructions checked against an architectural register model.
`timescale 1ns/1ps
module tb_alu_issue_sequencer;

  localparam int NI = 2;

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n      [NI];
  logic        instr_valid  [NI];
  logic        instr_ready  [NI];
  logic [31:0] instruction  [NI];
  logic        done         [NI];
  logic        illegal      [NI];
  logic        busy         [NI];
  logic        alu_enable   [NI];
  logic [2:0]  alu_funct3   [NI];
  logic [6:0]  alu_funct7   [NI];
  logic [31:0] alu_data_1   [NI];
  logic [31:0] alu_data_2   [NI];
  logic [31:0] alu_data_out [NI];
  logic [4:0]  dbg_addr     [NI];
  logic [31:0] dbg_data     [NI];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    alu_issue_sequencer #(.ALU_LATENCY((gi == 0) ? 1 : 4)) u_dut (
      .clock        (clock),
      .reset_n      (reset_n[gi]),
      .instr_valid  (instr_valid[gi]),
      .instr_ready  (instr_ready[gi]),
      .instruction  (instruction[gi]),
      .done         (done[gi]),
      .illegal      (illegal[gi]),
      .busy         (busy[gi]),
      .alu_enable   (alu_enable[gi]),
      .alu_funct3   (alu_funct3[gi]),
      .alu_funct7   (alu_funct7[gi]),
      .alu_data_1   (alu_data_1[gi]),
      .alu_data_2   (alu_data_2[gi]),
      .alu_data_out (alu_data_out[gi]),
      .dbg_addr     (dbg_addr[gi]),
      .dbg_data     (dbg_data[gi])
    );
  end

  int checks   = 0;
  int failures = 0;

  // RV32I integer ALU semantics.
  function automatic logic [31:0] alu_model(input logic [2:0] f3, input logic [6:0] f7,
                                            input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return f7[5] ? (a - b) : (a + b);
      3'b001:  return a << b[4:0];
      3'b010:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b011:  return (a < b) ? 32'd1 : 32'd0;
      3'b100:  return a ^ b;
      3'b101:  return f7[5] ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'b110:  return a | b;
      default: return a & b;
    endcase
  endfunction

  // ALU stand-in: result is valid only in the cycle exactly ALU_LATENCY cycles after
  // alu_enable rose, garbage otherwise, so wrong sampling time corrupts the result.
  int   en_age  [NI];
  logic en_prev [NI];
  always @(posedge clock) begin
    #1;
    for (int k = 0; k < NI; k++) begin
      if (!reset_n[k])                          en_age[k] = 0;
      else if (alu_enable[k] && !en_prev[k])    en_age[k] = 1;
      else if (en_age[k] != 0)                  en_age[k] = en_age[k] + 1;
      en_prev[k] = alu_enable[k];
      alu_data_out[k] = (en_age[k] == lat(k) + 1)
        ? alu_model(alu_funct3[k], alu_funct7[k], alu_data_1[k], alu_data_2[k])
        : 32'hDEADBEEF;
    end
  end

  // Architectural reference: register state and per-instruction expectations.
  logic [31:0] ref_regs [NI][32];

  typedef struct packed {
    logic        ill;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] wval;
    logic [4:0]  rd;
  } ref_t;

  function automatic ref_t ref_exec(input int k, input logic [31:0] ins);
    ref_t r;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    r = '0;
    r.rd  = ins[11:7];
    r.f3  = f3;
    r.d1  = ref_regs[k][ins[19:15]];
    if (opc == 7'b0110011) begin
      r.d2  = ref_regs[k][ins[24:20]];
      r.f7  = f7;
      r.ill = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
    end else if (opc == 7'b0010011) begin
      r.d2  = {{20{ins[31]}}, ins[31:20]};
      r.f7  = ((f3 == 3'd1) || (f3 == 3'd5)) ? f7 : 7'h00;
      r.ill = ((f3 == 3'd1) && (f7 != 7'h00)) ||
              ((f3 == 3'd5) && (f7 != 7'h00) && (f7 != 7'h20));
    end else begin
      r.ill = 1'b1;
    end
    r.wval = alu_model(r.f3, r.f7, r.d1, r.d2);
    return r;
  endfunction

  task automatic ref_commit(input int k, input ref_t r);
    if (!r.ill && (r.rd != 5'd0)) ref_regs[k][r.rd] = r.wval;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic        timeout;
    logic        busy_ok;
    logic        ill;
    logic [7:0]  ready_wait;
    logic [7:0]  done_cyc;
    logic [7:0]  en_cnt;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] dbg;
  } obs_t;

  // Offer one instruction (called at a negedge), follow it to done and record what
  // was seen. With hold_garbage the source keeps instr_valid high with another word
  // while the block is busy; that word must be ignored.
  task automatic run_instr(input int k, input logic [31:0] ins, input bit hold_garbage,
                           output obs_t o);
    int cyc;
    bit seen_en;
    o = '0;
    o.busy_ok = 1'b1;
    seen_en = 1'b0;
    dbg_addr[k] = ins[11:7];
    while (!instr_ready[k] && (o.ready_wait < 8'd10)) begin
      @(negedge clock);
      o.ready_wait++;
    end
    instruction[k] = ins;
    instr_valid[k] = 1'b1;
    @(negedge clock);
    if (hold_garbage) instruction[k] = 32'h7FF00F93;
    else              instr_valid[k] = 1'b0;
    cyc = 1;
    forever begin
      if (!busy[k]) o.busy_ok = 1'b0;
      if (alu_enable[k]) begin
        if (!seen_en) begin
          o.f3 = alu_funct3[k];
          o.f7 = alu_funct7[k];
          o.d1 = alu_data_1[k];
          o.d2 = alu_data_2[k];
        end
        seen_en = 1'b1;
        o.en_cnt++;
      end
      if (done[k]) begin
        o.done_cyc = 8'(cyc);
        o.ill      = illegal[k];
        o.dbg      = dbg_data[k];
        break;
      end
      if (cyc >= 20) begin
        o.timeout = 1'b1;
        break;
      end
      @(negedge clock);
      cyc++;
    end
    instr_valid[k] = 1'b0;
    @(negedge clock);
  endtask

  task automatic cmp_txn(input int k, input logic [31:0] ins, input obs_t o,
                         input logic e_ill, input logic [2:0] e_f3, input logic [6:0] e_f7,
                         input logic [31:0] e_d1, input logic [31:0] e_d2,
                         input logic [31:0] e_dbg);
    string t;
    t = $sformatf("dut%0d instr=%08h", k, ins);
    $display("txn dut=%0d instr=%08h illegal=%0b done_cycle=%0d enable_cycles=%0d rd_value=%08h",
             k, ins, o.ill, o.done_cyc, o.en_cnt, o.dbg);
    chk({t, " done_timeout"}, 32'(o.timeout), 32'd0);
    chk({t, " accept_wait"},  32'(o.ready_wait), 32'd0);
    chk({t, " busy_while_active"}, 32'(o.busy_ok), 32'd1);
    chk({t, " done_cycle"},   32'(o.done_cyc), e_ill ? 32'd2 : 32'(3 + lat(k)));
    chk({t, " illegal"},      32'(o.ill), 32'(e_ill));
    chk({t, " enable_cycles"}, 32'(o.en_cnt), e_ill ? 32'd0 : 32'(lat(k)));
    if (!e_ill) begin
      chk({t, " alu_funct3"}, 32'(o.f3), 32'(e_f3));
      chk({t, " alu_funct7"}, 32'(o.f7), 32'(e_f7));
      chk({t, " alu_data_1"}, o.d1, e_d1);
      chk({t, " alu_data_2"}, o.d2, e_d2);
    end
    chk({t, " rd_readback"}, o.dbg, e_dbg);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int sel;
    w   = $urandom;
    sel = $urandom_range(0, 9);
    if (sel < 5) begin
      w[6:0] = 7'b0110011;
      case ($urandom_range(0, 3))
        0, 1:    w[31:25] = 7'h00;
        2:       w[31:25] = 7'h20;
        default: ;
      endcase
    end else if (sel < 9) begin
      w[6:0] = 7'b0010011;
      if ((w[14:12] == 3'd1) || (w[14:12] == 3'd5)) begin
        case ($urandom_range(0, 3))
          0, 1:    w[31:25] = 7'h00;
          2:       w[31:25] = 7'h20;
          default: ;
        endcase
      end
    end
    return w;
  endfunction

  typedef struct {
    logic [31:0] ins;
    logic        ill;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] rd_val;
  } vec_t;

  vec_t vt [9];

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    ref_t r;
    logic [31:0] ins;

    // ins, illegal, funct3, funct7, data_1, data_2, rd value after retire
    vt[0] = '{32'h00500093, 1'b0, 3'd0, 7'h00, 32'h00000000, 32'h00000005, 32'h00000005};
    vt[1] = '{32'hFFD00113, 1'b0, 3'd0, 7'h00, 32'h00000000, 32'hFFFFFFFD, 32'hFFFFFFFD};
    vt[2] = '{32'h002081B3, 1'b0, 3'd0, 7'h00, 32'h00000005, 32'hFFFFFFFD, 32'h00000002};
    vt[3] = '{32'h40208233, 1'b0, 3'd0, 7'h20, 32'h00000005, 32'hFFFFFFFD, 32'h00000008};
    vt[4] = '{32'h00700013, 1'b0, 3'd0, 7'h00, 32'h00000000, 32'h00000007, 32'h00000000};
    vt[5] = '{32'h0000006F, 1'b1, 3'd0, 7'h00, 32'h00000000, 32'h00000000, 32'h00000000};
    vt[6] = '{32'h40115293, 1'b0, 3'd5, 7'h20, 32'hFFFFFFFD, 32'h00000401, 32'hFFFFFFFE};
    vt[7] = '{32'h40209233, 1'b1, 3'd0, 7'h00, 32'h00000000, 32'h00000000, 32'h00000008};
    vt[8] = '{32'h02109313, 1'b1, 3'd0, 7'h00, 32'h00000000, 32'h00000000, 32'h00000000};

    for (int k = 0; k < NI; k++) begin
      reset_n[k]     = 1'b1;
      instr_valid[k] = 1'b0;
      instruction[k] = 32'd0;
      dbg_addr[k]    = 5'd0;
      for (int a = 0; a < 32; a++) ref_regs[k][a] = 32'd0;
    end
    #2;
    for (int k = 0; k < NI; k++) reset_n[k] = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("dut%0d reset_outputs", k),
          {done[k], illegal[k], busy[k], alu_enable[k], alu_funct3[k], alu_funct7[k],
           alu_data_1[k][9:0], alu_data_2[k][9:0]}, 32'd0);
      chk($sformatf("dut%0d reset_operands", k), alu_data_1[k] | alu_data_2[k], 32'd0);
    end
    repeat (3) @(negedge clock);
    for (int k = 0; k < NI; k++) reset_n[k] = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("dut%0d ready_after_reset", k), 32'(instr_ready[k]), 32'd1);
      chk($sformatf("dut%0d busy_after_reset", k), 32'(busy[k]), 32'd0);
    end
    @(negedge clock);

    // Directed table on the latency-1 instance.
    for (int i = 0; i < 9; i++) begin
      run_instr(0, vt[i].ins, (i % 2) == 1, o);
      r = ref_exec(0, vt[i].ins);
      ref_commit(0, r);
      cmp_txn(0, vt[i].ins, o, vt[i].ill, vt[i].f3, vt[i].f7, vt[i].d1, vt[i].d2, vt[i].rd_val);
    end

    // Latency-4 instance: write x1, then reset during the second EXEC cycle.
    run_instr(1, 32'h00500093, 1'b0, o);
    r = ref_exec(1, 32'h00500093);
    ref_commit(1, r);
    cmp_txn(1, 32'h00500093, o, 1'b0, 3'd0, 7'h00, 32'd0, 32'd5, 32'd5);
    instruction[1] = 32'h001081B3;
    instr_valid[1] = 1'b1;
    dbg_addr[1]    = 5'd1;
    @(negedge clock);
    instr_valid[1] = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("dut1 exec_before_reset", 32'(alu_enable[1]), 32'd1);
    reset_n[1] = 1'b0;
    #1;
    chk("dut1 midop_reset_outputs",
        {done[1], illegal[1], busy[1], alu_enable[1], alu_funct3[1], alu_funct7[1]}, 32'd0);
    chk("dut1 midop_reset_operands", alu_data_1[1] | alu_data_2[1], 32'd0);
    chk("dut1 midop_reset_x1", dbg_data[1], 32'd0);
    for (int a = 0; a < 32; a++) ref_regs[1][a] = 32'd0;
    @(negedge clock);
    reset_n[1] = 1'b1;
    begin
      int done_seen;
      done_seen = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clock);
        if (done[1] || busy[1]) done_seen++;
      end
      chk("dut1 no_done_after_reset", 32'(done_seen), 32'd0);
    end
    chk("dut1 ready_after_release", 32'(instr_ready[1]), 32'd1);

    // Randomized instructions on both instances against the reference model.
    for (int k = 0; k < NI; k++) begin
      for (int n = 0; n < 40; n++) begin
        ins = rand_instr();
        run_instr(k, ins, $urandom_range(0, 1) == 1, o);
        r = ref_exec(k, ins);
        ref_commit(k, r);
        cmp_txn(k, ins, o, r.ill, r.f3, r.f7, r.d1, r.d2, ref_regs[k][r.rd]);
      end
    end

    // Full register-file sweep through the debug port.
    for (int k = 0; k < NI; k++) begin
      for (int a = 0; a < 32; a++) begin
        dbg_addr[k] = 5'(a);
        #1;
        chk($sformatf("dut%0d sweep_x%0d", k, a), dbg_data[k], ref_regs[k][a]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
